// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad row scanner.
// Also holds the rule that the key code must be wide enough for every key.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } kp_state_e;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 3;

  function automatic bit code_w_fits(input int rows, input int cols, input int code_w);
    return (2 ** code_w) >= (rows * cols);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
// Shared by the keypad scanner and the game timer.
module scan_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x3 keypad controller with one shared debounce path.
// Drives one row low at a time and reports debounced presses as row*COLS+col.
//
// state   | meaning
// SCAN    | walking rows, looking for any low column on a tick
// CONFIRM | row frozen, counting consecutive low ticks of the candidate
// PRESSED | one clk: key_valid pulse, key accepted
// RELEASE | row frozen, counting consecutive high ticks of the candidate
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CODE_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   column,
  output logic [ROWS-1:0]   row_n,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_down
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW = $clog2(DEBOUNCE_TICKS + 1);

  if (!code_w_fits(ROWS, COLS, CODE_W)) begin : g_code_w_check
    $error("keypad_scanner: CODE_W too narrow for ROWS*COLS");
  end

  kp_state_e         state_q, state_d;
  logic [COLS-1:0]   col_meta_q, col_s_q;
  logic [RW-1:0]     row_q, row_d, row_next;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [RW-1:0]     cand_row_q, cand_row_d;
  logic [CW-1:0]     cand_col_q, cand_col_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_down_q, key_down_d;
  logic              tick;
  logic              any_low;
  logic [CW-1:0]     low_col;
  logic              cand_high;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign row_next  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign cand_high = col_s_q[cand_col_q];

  // Scan from the top so the lowest-index low column is the one left standing.
  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s_q[c]) begin
        any_low = 1'b1;
        low_col = CW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_meta_q  <= '1;
      col_s_q     <= '1;
      row_q       <= '0;
      row_n_q     <= ~ROWS'(1);
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_meta_q  <= column;
      col_s_q     <= col_meta_q;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    key_down_d = key_down_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cand_row_d = row_q;
            cand_col_d = low_col;
            cnt_d      = NW'(1);
            state_d    = (DEBOUNCE_TICKS == 1) ? PRESSED : CONFIRM;
          end else begin
            row_d = row_next;
          end
        end
      end
      CONFIRM: begin
        if (tick) begin
          if (!cand_high) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == NW'(DEBOUNCE_TICKS)) state_d = PRESSED;
          end else begin
            state_d = SCAN;
          end
        end
      end
      PRESSED: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (tick) begin
          if (cand_high) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == NW'(DEBOUNCE_TICKS)) begin
              cnt_d      = '0;
              key_down_d = 1'b0;
              row_d      = row_next;
              state_d    = SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
    // Code and key_down are loaded together with the pulse so they are valid in its cycle.
    key_valid_d = (state_d == PRESSED);
    if (key_valid_d) begin
      key_code_d = CODE_W'(cand_row_d) * CODE_W'(COLS) + CODE_W'(cand_col_d);
      key_down_d = 1'b1;
    end
    row_n_d = ~(ROWS'(1) << row_d);
  end

  always_comb begin
    row_n     = row_n_q;
    key_valid = key_valid_q;
    key_code  = key_code_q;
    key_down  = key_down_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad matrix model.
// Expected codes, row sequence and latencies come from the scan rules, not the RTL.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 3;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int CODE_W   = 4;
  localparam int PRESS_BOUND = 2 + (ROWS + DEB) * TICK_DIV + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [COLS-1:0]   column;
  logic [ROWS-1:0]   row_n;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_down;

  logic [COLS-1:0] keys [ROWS];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int kv_high  = 0;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV),
    .DEBOUNCE_TICKS(DEB), .CODE_W(CODE_W)
  ) dut (
    .clk(clk), .reset(reset), .column(column), .row_n(row_n),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Closed switches pull their column low only while their row is driven low.
  always_comb begin
    column = '1;
    for (int r = 0; r < ROWS; r++)
      if (!row_n[r]) column = column & ~keys[r];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) kv_high <= kv_high + int'(key_valid);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++) keys[r] = '0;
  endtask

  task automatic do_reset();
    clear_keys();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_kv(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (key_valid === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic wait_up(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (key_down === 1'b0) begin
        waited = i;
        break;
      end
    end
  endtask

  function automatic logic [ROWS-1:0] row_pattern(input int r);
    logic [ROWS-1:0] p;
    p = '1;
    p[r] = 1'b0;
    return p;
  endfunction

  task automatic test_reset();
    clear_keys();
    reset = 1'b0;
    #13;
    n_checks++;
    if (row_n !== 4'b1110) begin n_fail++; $display("FAIL reset_row_n: got %b expected 1110", row_n); end
    n_checks++;
    if ({key_valid, key_down} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got valid=%b down=%b expected 0 0", key_valid, key_down); end
    n_checks++;
    if (key_code !== '0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_scan_rows();
    for (int n = 1; n <= 4 * ROWS * TICK_DIV / 2; n++) begin
      step();
      n_checks++;
      if (row_n !== row_pattern((n / TICK_DIV) % ROWS) || key_valid !== 1'b0 || key_down !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_rows n=%0d: got row_n=%b valid=%b down=%b expected row_n=%b 0 0",
                 n, row_n, key_valid, key_down, row_pattern((n / TICK_DIV) % ROWS));
      end
    end
  endtask

  task automatic test_press_release();
    int w, base, rel, exp_fall;
    do_reset();
    keys[2] = 3'b010;
    base = kv_high;
    wait_kv(60, w);
    n_checks++;
    if (cyc !== (2 + DEB) * TICK_DIV) begin n_fail++; $display("FAIL press_latency: got cycle %0d expected %0d", cyc, (2 + DEB) * TICK_DIV); end
    n_checks++;
    if (key_code !== 4'd7 || key_down !== 1'b1) begin n_fail++; $display("FAIL press_code: got code=%0d down=%b expected 7 1", key_code, key_down); end
    step();
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_width: got valid=%b expected 0", key_valid); end
    repeat (40) step();
    n_checks++;
    if (kv_high - base !== 1 || key_down !== 1'b1) begin n_fail++; $display("FAIL press_hold: got pulses=%0d down=%b expected 1 1", kv_high - base, key_down); end
    while (cyc % TICK_DIV != 1) step();
    rel = cyc;
    keys[2] = '0;
    exp_fall = rel - 1 + DEB * TICK_DIV;
    wait_up(60, w);
    n_checks++;
    if (cyc !== exp_fall) begin n_fail++; $display("FAIL release_time: got cycle %0d expected %0d", cyc, exp_fall); end
    n_checks++;
    if (row_n !== row_pattern(3)) begin n_fail++; $display("FAIL release_row: got %b expected %b", row_n, row_pattern(3)); end
    repeat (TICK_DIV - 1) step();
    n_checks++;
    if (row_n !== row_pattern(3)) begin n_fail++; $display("FAIL resume_row3: got %b expected %b", row_n, row_pattern(3)); end
  endtask

  task automatic test_bounce();
    int base;
    do_reset();
    base = kv_high;
    keys[0] = 3'b001;
    while (cyc < 5) step();
    keys[0] = '0;
    while (cyc < 16) begin
      n_checks++;
      if (row_n !== row_pattern(cyc < 3 * TICK_DIV ? 0 : 1)) begin
        n_fail++;
        $display("FAIL bounce_row cyc=%0d: got %b expected %b", cyc, row_n, row_pattern(cyc < 3 * TICK_DIV ? 0 : 1));
      end
      step();
    end
    repeat (20) step();
    n_checks++;
    if (kv_high - base !== 0 || key_down !== 1'b0) begin n_fail++; $display("FAIL bounce_no_event: got pulses=%0d down=%b expected 0 0", kv_high - base, key_down); end
  endtask

  task automatic test_multi_col();
    int w;
    do_reset();
    keys[1] = 3'b101;
    wait_kv(60, w);
    n_checks++;
    if (w < 0 || key_code !== 4'd3 || cyc !== (1 + DEB) * TICK_DIV) begin
      n_fail++;
      $display("FAIL multi_col: got code=%0d cycle=%0d expected 3 at %0d", key_code, cyc, (1 + DEB) * TICK_DIV);
    end
    clear_keys();
    wait_up(60, w);
  endtask

  task automatic test_release_bounce();
    int w, base, hi_run;
    bit pat [6];
    bit exp_down;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    keys[0] = 3'b100;
    base = kv_high;
    wait_kv(60, w);
    n_checks++;
    if (w < 0 || key_code !== 4'd2) begin n_fail++; $display("FAIL relb_press: got code=%0d waited=%0d expected 2", key_code, w); end
    hi_run = 0;
    for (int i = 0; i < 6; i++) begin
      while (cyc % TICK_DIV != 1) step();
      keys[0][2] = ~pat[i];
      while (cyc % TICK_DIV != 0) step();
      hi_run = pat[i] ? hi_run + 1 : 0;
      exp_down = (hi_run < DEB);
      n_checks++;
      if (key_down !== exp_down) begin n_fail++; $display("FAIL relb_down tick=%0d: got %b expected %b", i, key_down, exp_down); end
    end
    repeat (10) step();
    n_checks++;
    if (kv_high - base !== 1) begin n_fail++; $display("FAIL relb_pulses: got %0d expected 1", kv_high - base); end
  endtask

  task automatic test_reset_midway();
    int w;
    do_reset();
    keys[3] = 3'b010;
    wait_kv(60, w);
    repeat (7) step();
    n_checks++;
    if (key_down !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got down=%b expected 1", key_down); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (row_n !== 4'b1110 || key_down !== 1'b0 || key_valid !== 1'b0 || key_code !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got row_n=%b down=%b valid=%b code=%0d expected 1110 0 0 0", row_n, key_down, key_valid, key_code);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_kv(PRESS_BOUND, w);
    n_checks++;
    if (w < 0 || key_code !== 4'd10 || cyc !== (3 + DEB) * TICK_DIV) begin
      n_fail++;
      $display("FAIL midrst_redetect: got code=%0d cycle=%0d expected 10 at %0d", key_code, cyc, (3 + DEB) * TICK_DIV);
    end
    clear_keys();
    wait_up(60, w);
  endtask

  task automatic test_random();
    int w, r, c, mask, base, exp_code;
    for (int it = 0; it < 10; it++) begin
      r = int'($urandom_range(0, ROWS - 1));
      mask = int'($urandom_range(1, (1 << COLS) - 1));
      c = 0;
      while (((mask >> c) & 1) == 0) c++;
      exp_code = r * COLS + c;
      repeat ($urandom_range(0, 15)) step();
      base = kv_high;
      keys[r] = COLS'(mask);
      wait_kv(PRESS_BOUND, w);
      n_checks++;
      if (w < 0 || key_code !== CODE_W'(exp_code)) begin
        n_fail++;
        $display("FAIL rand_press it=%0d: got code=%0d waited=%0d expected %0d within %0d", it, key_code, w, exp_code, PRESS_BOUND);
      end
      repeat ($urandom_range(1, 20)) step();
      n_checks++;
      if (kv_high - base !== 1 || key_down !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_hold it=%0d: got pulses=%0d down=%b expected 1 1", it, kv_high - base, key_down);
      end
      clear_keys();
      wait_up(2 + (DEB + 1) * TICK_DIV + 1, w);
      n_checks++;
      if (w < 0) begin n_fail++; $display("FAIL rand_release it=%0d: got down=%b expected 0", it, key_down); end
    end
  endtask

  initial begin
    clear_keys();
    test_reset();
    test_scan_rows();
    test_press_release();
    test_bounce();
    test_multi_col();
    test_release_bounce();
    test_reset_midway();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
